led_pio_out: RTL

- Avalon-MM write-side PIO slave that drives an LED or output pin bank.
- Output-direction counterpart of the team's input PIO readers.
- Holds a data register with atomic bit set and bit clear, a per-bit blink mask, and a programmable blink prescaler.
- Sits between the Nios/Avalon interconnect and the top-level LED pins.
- Single-cycle writes, no waitrequest; registered readback with 1-cycle latency.

---
 rtl/led_pio_pkg.sv | 31 +++
 rtl/led_blink_prescaler.sv | 57 +++++
 rtl/led_pio_out.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED/output PIO slave: register map, STATUS layout,
// and the decoded write-request payload.
package led_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BUS_W  = 32;

    // Word addresses of the slave registers
    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd6;

    // STATUS register bit carrying the blink phase
    localparam int unsigned STATUS_PHASE_BIT = 0;

    // Decoded single-cycle Avalon write request
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BUS_W-1:0]  wdata;
    } pio_wr_t;

    // Avalon write strobe: selected and write_n low
    function automatic logic is_write(input logic cs, input logic wn);
        return cs & ~wn;
    endfunction

endpackage

// File: rtl/led_blink_prescaler.sv
// Blink phase generator: counts cnt down from PERIOD and flips phase at
// terminal count, giving half-periods of PERIOD+1 cycles. PERIOD == 0 parks
// the counter at zero with phase forced high.
module led_blink_prescaler #(
    parameter int unsigned          PERIOD_W       = 24,
    parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = PERIOD_W'(2499999)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_d;
    logic [PERIOD_W-1:0] cnt_q;
    logic                phase_d;
    logic                phase_q;
    logic                tc_c;

    // Terminal count of the current half-period
    assign tc_c = (cnt_q == '0);

    // Next counter/phase; 'period' already carries a same-edge PERIOD write,
    // so a reload on terminal count and a bus load both pick up the new value
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else begin
            if (tc_c) begin
                phase_d = ~phase_q;
            end
            if (tc_c || load) begin
                cnt_d = period;
            end else begin
                cnt_d = cnt_q - PERIOD_W'(1);
            end
        end
    end

    // Counter and phase registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= DEFAULT_PERIOD;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_pio_out.sv
// Avalon-MM write-side PIO slave driving an LED/output pin bank.
// DATA register with atomic OUTSET/OUTCLEAR, registered 1-cycle readback.
// Optional blink support (MASK, PERIOD, STATUS.phase) under LED_PIO_BLINK_EN.
module led_pio_out
    import led_pio_pkg::*;
#(
    parameter int unsigned          WIDTH          = 10,
    parameter int unsigned          PERIOD_W       = 24,
    parameter logic [WIDTH-1:0]     RESET_VALUE    = '0,
    parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = PERIOD_W'(2499999)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    output logic [WIDTH-1:0]  out_port
);

    pio_wr_t          req_c;
    logic [WIDTH-1:0] wbits_c;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic [BUS_W-1:0] readdata_d;
    logic [BUS_W-1:0] readdata_q;
    logic             unused_wdata_c;

    // Bundle the bus write into one request
    always_comb begin
        req_c.wr    = is_write(chipselect, write_n);
        req_c.addr  = address;
        req_c.wdata = writedata;
    end

    assign wbits_c = req_c.wdata[WIDTH-1:0];

    // Write bits above the implemented register widths carry no meaning
    assign unused_wdata_c = ^req_c.wdata;

    // DATA next value: plain write, atomic set, atomic clear
    always_comb begin
        data_d = data_q;
        if (req_c.wr) begin
            case (req_c.addr)
                ADDR_DATA:     data_d = wbits_c;
                ADDR_OUTSET:   data_d = data_q | wbits_c;
                ADDR_OUTCLEAR: data_d = data_q & ~wbits_c;
                default:       data_d = data_q;
            endcase
        end
    end

    // DATA register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0]    mask_d;
    logic [WIDTH-1:0]    mask_q;
    logic [PERIOD_W-1:0] period_d;
    logic [PERIOD_W-1:0] period_q;
    logic                period_load_c;
    logic                phase;

    assign period_load_c = req_c.wr && (req_c.addr == ADDR_PERIOD);

    // MASK and PERIOD next values
    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        if (req_c.wr && (req_c.addr == ADDR_MASK)) begin
            mask_d = wbits_c;
        end
        if (period_load_c) begin
            period_d = req_c.wdata[PERIOD_W-1:0];
        end
    end

    // MASK and PERIOD registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= '0;
            period_q <= DEFAULT_PERIOD;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end

    led_blink_prescaler #(
        .PERIOD_W       (PERIOD_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_d),
        .load    (period_load_c),
        .phase   (phase)
    );

    // Masked bits go dark while phase is low; all terms are flop outputs
    assign out_port = data_q & ~(mask_q & {WIDTH{~phase}});
`else
    logic unused_cfg_c;

    // Blink configuration has no effect without blink support
    assign unused_cfg_c = ^DEFAULT_PERIOD;

    assign out_port = data_q;
`endif

    // Readback mux, zero-extended to the bus width
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = BUS_W'(data_q);
`ifdef LED_PIO_BLINK_EN
            ADDR_MASK:   readdata_d = BUS_W'(mask_q);
            ADDR_PERIOD: readdata_d = BUS_W'(period_q);
            ADDR_STATUS: readdata_d[STATUS_PHASE_BIT] = phase;
`else
            ADDR_MASK, ADDR_PERIOD, ADDR_STATUS: readdata_d = '0;
`endif
            default: readdata_d = '0;
        endcase
    end

    // Registered read data, updated every clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule
